// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester and SRAM signal bundle for mem_arbiter
// slave is the arbiter's view; master is the pipeline/SRAM side driving requests and mem_do.
interface mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ready;
  logic [31:0] if_rdata;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_bweb;
  logic        dm_ready;
  logic [31:0] dm_rdata;
  logic        mem_ceb;
  logic        mem_web;
  logic [13:0] mem_a;
  logic [31:0] mem_di;
  logic [31:0] mem_bweb;
  logic [31:0] mem_do;
  logic        stall;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_bweb, mem_do,
    output if_ready, if_rdata, dm_ready, dm_rdata,
    output mem_ceb, mem_web, mem_a, mem_di, mem_bweb, stall
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_bweb, mem_do,
    input  if_ready, if_rdata, dm_ready, dm_rdata,
    input  mem_ceb, mem_web, mem_a, mem_di, mem_bweb, stall
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port (fetch/data) arbiter onto a single-port SRAM
// Issues in IDLE, completes in BUSY; dm wins ties unless it has already won three in a row.
module mem_arbiter (
  input  logic             clk,
  input  logic             rst,
  mem_arbiter_if.slave     bus
);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e      state_q;
  logic        owner_dm_q;
  logic        we_q;
  logic [1:0]  streak_q;
  logic [1:0]  streak_d;

  logic        any_req;
  logic        grant_dm;
  logic        issue;
  logic        store;
  logic        done;
  logic [31:0] sel_addr;

  assign any_req  = bus.if_req | bus.dm_req;
  assign grant_dm = bus.dm_req & (~bus.if_req | (streak_q != 2'd3));

  // streak counts consecutive dm wins that actually made the fetch side wait
  always_comb begin
    streak_d = 2'd0;
    if (grant_dm && bus.if_req)
      streak_d = (streak_q == 2'd3) ? 2'd3 : streak_q + 2'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_dm_q <= 1'b0;
      we_q       <= 1'b0;
      streak_q   <= 2'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            state_q    <= BUSY;
            owner_dm_q <= grant_dm;
            we_q       <= grant_dm & bus.dm_we;
            streak_q   <= streak_d;
          end
        end
        BUSY: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // rst gates the combinational issue path so outputs hold reset values while it is high
  assign issue    = ~rst & (state_q == IDLE) & any_req;
  assign store    = issue & grant_dm & bus.dm_we;
  assign done     = ~rst & (state_q == BUSY);
  assign sel_addr = grant_dm ? bus.dm_addr : bus.if_addr;

  assign bus.mem_ceb  = ~issue;
  assign bus.mem_web  = ~store;
  assign bus.mem_a    = issue ? sel_addr[15:2] : 14'd0;
  assign bus.mem_di   = store ? bus.dm_wdata : 32'd0;
  assign bus.mem_bweb = store ? bus.dm_bweb : 32'hFFFF_FFFF;

  assign bus.if_ready = done & ~owner_dm_q;
  assign bus.dm_ready = done & owner_dm_q;
  assign bus.if_rdata = bus.if_ready ? bus.mem_do : 32'd0;
  assign bus.dm_rdata = (bus.dm_ready & ~we_q) ? bus.mem_do : 32'd0;

  assign bus.stall = (bus.if_req & ~bus.if_ready) | (bus.dm_req & ~bus.dm_ready);

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.if_addr[31:16], bus.if_addr[1:0],
                              bus.dm_addr[31:16], bus.dm_addr[1:0]};

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - table-driven check of mem_arbiter plus reset/drop/starvation sequences
module tb_mem_arbiter;

  localparam logic        H  = 1'b1;
  localparam logic        L  = 1'b0;
  localparam logic [31:0] O  = 32'hFFFF_FFFF;
  localparam logic [31:0] Z  = 32'h0;
  localparam logic [31:0] RD = 32'hA0A0_A0A0;
  localparam logic [31:0] GB = 32'h5A5A_5A5A;
  localparam logic [31:0] IA = 32'h0000_0200;
  localparam logic [31:0] DA = 32'h0000_0300;
  localparam logic [31:0] WD = 32'h1111_1111;

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_bweb;
    logic [31:0] mem_do;
    logic        e_ceb;
    logic        e_web;
    logic [13:0] e_a;
    logic [31:0] e_di;
    logic [31:0] e_bweb;
    logic        e_ifr;
    logic [31:0] e_ifd;
    logic        e_dmr;
    logic [31:0] e_dmd;
    logic        e_stall;
    logic        e_quiet;
  } vec_t;

  logic clk;
  logic rst;
  int   pass_cnt;
  int   total_cnt;

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  vec_t tbl [17];
  vec_t bd, bd_b, bi, bi_b, da, da_b, ifa, ifa_b, ifd_b, q, rst_both;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h", name, act, exp);
    else
      pass_cnt++;
  endtask

  task automatic drive(input vec_t v);
    bus.if_req   = v.if_req;
    bus.if_addr  = v.if_addr;
    bus.dm_req   = v.dm_req;
    bus.dm_we    = v.dm_we;
    bus.dm_addr  = v.dm_addr;
    bus.dm_wdata = v.dm_wdata;
    bus.dm_bweb  = v.dm_bweb;
    bus.mem_do   = v.mem_do;
  endtask

  task automatic check_v(input string tag, input vec_t v);
    chk({tag, ".ceb"}, 32'(bus.mem_ceb), 32'(v.e_ceb));
    if (!v.e_ceb || v.e_quiet) begin
      chk({tag, ".web"},  32'(bus.mem_web), 32'(v.e_web));
      chk({tag, ".a"},    32'(bus.mem_a),   32'(v.e_a));
      chk({tag, ".bweb"}, bus.mem_bweb,     v.e_bweb);
    end
    if (!v.e_web || v.e_quiet)
      chk({tag, ".di"}, bus.mem_di, v.e_di);
    chk({tag, ".if_ready"}, 32'(bus.if_ready), 32'(v.e_ifr));
    chk({tag, ".if_rdata"}, bus.if_rdata,      v.e_ifd);
    chk({tag, ".dm_ready"}, 32'(bus.dm_ready), 32'(v.e_dmr));
    chk({tag, ".dm_rdata"}, bus.dm_rdata,      v.e_dmd);
    chk({tag, ".stall"},    32'(bus.stall),    32'(v.e_stall));
  endtask

  // entered just after a falling edge; leaves just after the next falling edge
  task automatic step(input string tag, input vec_t v);
    drive(v);
    #2;
    check_v(tag, v);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;

    //           ifq ifaddr        dmq we dmaddr         wdata          bweb           mem_do          ceb web a       di             bweb           ifr ifd             dmr dmd             stall quiet
    tbl[0]  = '{L, Z,            L, L, Z,            Z,            O,            32'h12345678, H, H, 14'h000, Z,            O,            L, Z,            L, Z,            L, H};
    tbl[1]  = '{H, 32'h00000104, L, L, Z,            Z,            O,            GB,           L, H, 14'h041, Z,            O,            L, Z,            L, Z,            H, L};
    tbl[2]  = '{H, 32'h00000104, L, L, Z,            Z,            O,            32'hCAFEF00D, H, H, 14'h000, Z,            O,            H, 32'hCAFEF00D, L, Z,            L, L};
    tbl[3]  = '{L, Z,            L, L, Z,            Z,            O,            32'h0BADF00D, H, H, 14'h000, Z,            O,            L, Z,            L, Z,            L, H};
    tbl[4]  = '{L, Z,            H, H, 32'h00010008, 32'hDEADBEEF, 32'hFFFF0000, GB,           L, L, 14'h002, 32'hDEADBEEF, 32'hFFFF0000, L, Z,            L, Z,            H, L};
    tbl[5]  = '{L, Z,            H, H, 32'h00010008, 32'hDEADBEEF, 32'hFFFF0000, 32'h55AA55AA, H, H, 14'h000, Z,            O,            L, Z,            H, Z,            L, L};
    tbl[6]  = '{H, IA,           H, L, DA,           WD,           Z,            32'hEEEE0000, L, H, 14'h0C0, Z,            O,            L, Z,            L, Z,            H, L};
    tbl[7]  = '{H, IA,           H, L, DA,           WD,           Z,            32'h000000A1, H, H, 14'h000, Z,            O,            L, Z,            H, 32'h000000A1, H, L};
    tbl[8]  = '{H, IA,           H, L, DA,           WD,           Z,            GB,           L, H, 14'h0C0, Z,            O,            L, Z,            L, Z,            H, L};
    tbl[9]  = '{H, IA,           H, L, DA,           WD,           Z,            32'h000000A2, H, H, 14'h000, Z,            O,            L, Z,            H, 32'h000000A2, H, L};
    tbl[10] = '{H, IA,           H, L, DA,           WD,           Z,            GB,           L, H, 14'h0C0, Z,            O,            L, Z,            L, Z,            H, L};
    tbl[11] = '{H, IA,           H, L, DA,           WD,           Z,            32'h000000A3, H, H, 14'h000, Z,            O,            L, Z,            H, 32'h000000A3, H, L};
    tbl[12] = '{H, IA,           H, L, DA,           WD,           Z,            GB,           L, H, 14'h080, Z,            O,            L, Z,            L, Z,            H, L};
    tbl[13] = '{H, IA,           H, L, DA,           WD,           Z,            32'h000000B4, H, H, 14'h000, Z,            O,            H, 32'h000000B4, L, Z,            H, L};
    tbl[14] = '{H, IA,           H, L, DA,           WD,           Z,            GB,           L, H, 14'h0C0, Z,            O,            L, Z,            L, Z,            H, L};
    tbl[15] = '{H, IA,           H, L, DA,           WD,           Z,            32'h000000A5, H, H, 14'h000, Z,            O,            L, Z,            H, 32'h000000A5, H, L};
    tbl[16] = '{L, Z,            L, L, Z,            Z,            O,            Z,            H, H, 14'h000, Z,            O,            L, Z,            L, Z,            L, H};

    bd       = '{H, IA,           H, L, DA, WD, Z, GB, L, H, 14'h0C0, Z, O, L, Z,  L, Z,  H, L};
    bd_b     = '{H, IA,           H, L, DA, WD, Z, RD, H, H, 14'h000, Z, O, L, Z,  H, RD, H, L};
    bi       = '{H, IA,           H, L, DA, WD, Z, GB, L, H, 14'h080, Z, O, L, Z,  L, Z,  H, L};
    bi_b     = '{H, IA,           H, L, DA, WD, Z, RD, H, H, 14'h000, Z, O, H, RD, L, Z,  H, L};
    da       = '{L, IA,           H, L, DA, WD, Z, GB, L, H, 14'h0C0, Z, O, L, Z,  L, Z,  H, L};
    da_b     = '{L, IA,           H, L, DA, WD, Z, RD, H, H, 14'h000, Z, O, L, Z,  H, RD, L, L};
    ifa      = '{H, 32'h00000104, L, L, Z,  Z,  O, GB, L, H, 14'h041, Z, O, L, Z,  L, Z,  H, L};
    ifa_b    = '{H, 32'h00000104, L, L, Z,  Z,  O, RD, H, H, 14'h000, Z, O, H, RD, L, Z,  L, L};
    ifd_b    = '{L, 32'h00000104, L, L, Z,  Z,  O, RD, H, H, 14'h000, Z, O, H, RD, L, Z,  L, L};
    q        = '{L, Z,            L, L, Z,  Z,  O, Z,  H, H, 14'h000, Z, O, L, Z,  L, Z,  L, H};
    rst_both = '{H, IA,           H, L, DA, WD, Z, RD, H, H, 14'h000, Z, O, L, Z,  L, Z,  H, H};

    // reset values hold even with both requesters asserting
    rst = 1'b1;
    drive(rst_both);
    #3;
    check_v("reset", rst_both);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 17; i++)
      step($sformatf("tbl%0d", i), tbl[i]);

    // starvation counter is cleared by a dm grant made while fetch is idle
    step("st_da0", da);  step("st_da0b", da_b);
    step("st_bd1", bd);  step("st_bd1b", bd_b);
    step("st_bd2", bd);  step("st_bd2b", bd_b);
    step("st_da3", da);  step("st_da3b", da_b);
    step("st_bd4", bd);  step("st_bd4b", bd_b);
    step("st_bd5", bd);  step("st_bd5b", bd_b);
    step("st_bd6", bd);  step("st_bd6b", bd_b);
    step("st_bi7", bi);  step("st_bi7b", bi_b);
    step("st_q", q);

    // reset during the BUSY cycle of a dm load with streak at 3
    step("rs_bd1", bd);  step("rs_bd1b", bd_b);
    step("rs_bd2", bd);  step("rs_bd2b", bd_b);
    step("rs_bd3", bd);
    drive(bd_b);
    #2;
    check_v("rs_busy", bd_b);
    #1;
    rst = 1'b1;
    drive(rst_both);
    #1;
    check_v("rs_async", rst_both);
    @(posedge clk);
    @(negedge clk);
    #2;
    check_v("rs_hold", rst_both);
    @(negedge clk);
    rst = 1'b0;
    step("rs_first", bd);
    step("rs_firstb", bd_b);
    step("rs_ifa", ifa);
    step("rs_ifab", ifa_b);
    step("rs_q", q);

    // fetch drops its request in its own completion cycle
    step("dr_ifa", ifa);
    step("dr_ifdb", ifd_b);
    step("dr_q", q);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have these ports (name, direction, width, meaning):
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- if_req  in  1  fetch request; held until if_ready.
- if_addr  in  32  fetch byte address.
- if_ready  out  1  one-cycle fetch completion pulse.
- if_rdata  out  32  fetch data; valid when if_ready is high.
- dm_req  in  1  data request; held until dm_ready.
- dm_we  in  1  1=store, 0=load.
- dm_addr  in  32  data byte address.
- dm_wdata  in  32  store data.
- dm_bweb  in  32  store bit-write-enable, active-low (0=write bit).
- dm_ready  out  1  one-cycle data completion pulse.
- dm_rdata  out  32  load data; valid when dm_ready is high and dm_we was 0.
- mem_ceb  out  1  SRAM chip enable, active-low.
- mem_web  out  1  SRAM write enable; 0=write, 1=read.
- mem_a  out  14  SRAM word address.
- mem_di  out  32  SRAM write data.
- mem_bweb  out  32  SRAM bit-write-enable, active-low.
- mem_do  in  32  SRAM read data; valid one cycle after a read issue.
- stall  out  1  pipeline stall request.

Function
REQ-002 SHALL implement an FSM with two states:
- IDLE: no access in flight.
- BUSY: access issued in the previous cycle, completing this cycle.
REQ-003 In IDLE with no request, SHALL hold mem_ceb=1, mem_web=1, mem_a=0, mem_di=0 and mem_bweb=all-ones.
REQ-004 In IDLE with at least one request, SHALL:
- select one owner per REQ-008;
- drive mem_ceb=0 and mem_a=addr[15:2] of the owner;
- for a dm store, drive mem_web=0, mem_di=dm_wdata, mem_bweb=dm_bweb;
- otherwise drive mem_web=1 and mem_bweb=all-ones;
- register the owner and dm_we;
- go to BUSY.
REQ-005 In BUSY, SHALL:
- pulse the owner's ready;
- drive the owner's rdata=mem_do for reads;
- drive mem_ceb=1;
- return to IDLE unconditionally.
Latency is 2 cycles from request to ready; peak throughput is one access per 2 cycles.
REQ-006 if_rdata and dm_rdata SHALL be 0 whenever their ready is low. dm_rdata SHALL be 0 on a store completion.
REQ-007 Address bits [1:0] and [31:16] SHALL be ignored, so addresses wrap at 64 KiB.
REQ-008 Arbitration SHALL follow these rules:
- With only one request, grant it.
- With both requesting, grant dm unless streak==3, in which case grant if.
REQ-009 SHALL maintain a 2-bit counter, streak, updated at each grant:
- dm granted while if_req is high: increment, saturating at 3.
- if granted: clear to 0.
- dm granted while if_req is low: clear to 0.
REQ-010 A requester that drops req while it owns the access SHALL still have the access complete and its ready pulsed. Requests are never cancelled once issued.
REQ-011 stall SHALL equal (if_req AND NOT if_ready) OR (dm_req AND NOT dm_ready), combinationally.
REQ-012 The owner's req is high during its ready cycle. Because BUSY always returns to IDLE, it SHALL NOT be re-granted in that cycle; a still-high req in the following IDLE cycle is a new request.
REQ-013 Only the owner's ready SHALL ever be high. if_ready and dm_ready SHALL never be high in the same cycle.

Reset
REQ-014 On rst=1, asynchronously and regardless of state, SHALL set:
- state=IDLE, streak=0, owner and registered dm_we cleared;
- if_ready=0, dm_ready=0, if_rdata=0, dm_rdata=0;
- mem_ceb=1, mem_web=1, mem_a=0, mem_di=0, mem_bweb=all-ones.
REQ-015 Reset asserted during BUSY SHALL abort the access: no ready pulse is produced after reset releases.
REQ-016 The first grant SHALL be possible in the first cycle after rst deasserts.

Verification
REQ-017 Lone fetch: if_req=1, if_addr=0x0000_0104 -> cycle 0: mem_ceb=0, mem_web=1, mem_a=0x041; cycle 1: if_ready=1, if_rdata=mem_do.
REQ-018 Store: dm_req=1, dm_we=1, dm_addr=0x0001_0008, dm_wdata=0xDEADBEEF, dm_bweb=0xFFFF0000 -> cycle 0: mem_a=0x002 (wrapped), mem_web=0, mem_di=0xDEADBEEF, mem_bweb=0xFFFF0000; cycle 1: dm_ready=1, dm_rdata=0.
REQ-019 Simultaneous requests: if_req and dm_req held continuously -> grant order dm, dm, dm, if, dm, ...; stall=1 in every cycle where a requester is not ready.
REQ-020 Starvation reset: dm granted twice with if_req high, then if_req low for one grant, then both request -> streak is 0 and dm is granted.
REQ-021 Reset mid-access: rst pulsed during BUSY of a dm load -> no dm_ready afterwards, all outputs at reset values, streak=0; a new if_req completes in 2 cycles.
REQ-022 Request drop: if_req deasserted in the BUSY cycle of its own access -> if_ready still pulses and the next IDLE issues nothing.
